// File: rtl/mpu_pkg.sv
// Shared types and helpers for the sequential MPU matrix multiplier.
// reduce() works on a wide signed sum so any accumulator width can feed it.
package mpu_pkg;

   localparam int MPU_N      = 5;
   localparam int MPU_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   typedef logic signed [63:0] wide_t;

   typedef struct packed {
      wide_t value;
      logic  ovf;
   } red_t;

   // Element index of (r,c) in a row-major n x n flattened matrix.
   function automatic int elem_offset(input int r, input int c, input int n);
      return r * n + c;
   endfunction

   // value: clamped when saturating, else the exact sum (caller keeps the low dw bits).
   function automatic red_t reduce(input wide_t sum, input logic saturate, input int dw);
      wide_t hi;
      wide_t lo;
      red_t  res;
      hi        = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo        = -hi - wide_t'(1);
      res.ovf   = (sum > hi) || (sum < lo);
      res.value = sum;
      if (saturate && (sum > hi))
         res.value = hi;
      else if (saturate && (sum < lo))
         res.value = lo;
      return res;
   endfunction

endpackage

// File: rtl/mpu_mac_sat.sv
// One multiply-accumulate step plus the DATA_W reduction of the new sum.
module mpu_mac_sat
   import mpu_pkg::*;
#(
   parameter int DATA_W = MPU_DATA_W,
   parameter int ACC_W  = 2 * MPU_DATA_W + 3
)(
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic                     saturate,
   output logic signed [ACC_W-1:0]  next_acc,
   output logic signed [DATA_W-1:0] reduced,
   output logic                     ovf
);

   logic signed [2*DATA_W-1:0] prod;
   red_t                       red;
   logic                       unused_hi;

   always_comb begin
      prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
      next_acc = acc + ACC_W'(prod);
      red      = reduce(wide_t'(next_acc), saturate, DATA_W);
      reduced  = red.value[DATA_W-1:0];
      ovf      = red.ovf;
   end

   assign unused_hi = ^red.value[63:DATA_W];

endmodule

// File: rtl/mpu_mul_seq.sv
// Sequential C = A x B for signed size x size matrices, one MAC per clock,
// with start/busy/done handshake, wrap/saturate reduction and size checking.
module mpu_mul_seq
   import mpu_pkg::*;
#(
   parameter int N      = MPU_N,
   parameter int DATA_W = MPU_DATA_W,
   parameter int SIZE_W = $clog2(N + 1),
   parameter int ACC_W  = 2 * DATA_W + $clog2(N)
)(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [SIZE_W-1:0]       size,
   input  logic                    saturate,
   input  logic [0:N*N*DATA_W-1]   matrix_a,
   input  logic [0:N*N*DATA_W-1]   matrix_b,
   output logic [0:N*N*DATA_W-1]   result,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic                    error
);

   localparam int                MW       = N * N * DATA_W;
   localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(N);
   localparam logic [SIZE_W-1:0] ONE      = SIZE_W'(1);

   state_t                   state;
   logic [0:MW-1]            a_q, b_q;
   logic [SIZE_W-1:0]        size_q, i, j, k, last;
   logic                     sat_q;
   logic signed [ACC_W-1:0]  acc, next_acc;
   logic signed [DATA_W-1:0] a_el, b_el, reduced;
   logic                     ovf, size_ok;

   assign last    = size_q - ONE;
   assign size_ok = (size != '0) && (size <= SIZE_MAX);
   assign a_el    = a_q[DATA_W*elem_offset(int'(i), int'(k), N) +: DATA_W];
   assign b_el    = b_q[DATA_W*elem_offset(int'(k), int'(j), N) +: DATA_W];

   mpu_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .acc      (acc),
      .a        (a_el),
      .b        (b_el),
      .saturate (sat_q),
      .next_acc (next_acc),
      .reduced  (reduced),
      .ovf      (ovf)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         error    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         size_q   <= '0;
         sat_q    <= 1'b0;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         acc      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               result   <= '0;
               overflow <= 1'b0;
               if (size_ok) begin
                  a_q    <= matrix_a;
                  b_q    <= matrix_b;
                  size_q <= size;
                  sat_q  <= saturate;
                  error  <= 1'b0;
                  acc    <= '0;
                  i      <= '0;
                  j      <= '0;
                  k      <= '0;
                  busy   <= 1'b1;
                  state  <= MAC;
               end else begin
                  // Illegal size completes immediately without ever raising busy.
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            MAC: begin
               if (k != last) begin
                  acc <= next_acc;
                  k   <= k + ONE;
               end else begin
                  result[DATA_W*elem_offset(int'(i), int'(j), N) +: DATA_W] <= reduced;
                  overflow <= overflow | ovf;
                  acc      <= '0;
                  k        <= '0;
                  if (j != last) begin
                     j <= j + ONE;
                  end else begin
                     j <= '0;
                     if (i != last) begin
                        i <= i + ONE;
                     end else begin
                        i     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mpu_mul_seq.md
Name: mpu_mul_seq

Overview:
- Sequential, parametrised successor to the combinational 5x5 int8 matrix multiplier in the MPU datapath.
- Computes C = A x B for square signed matrices of runtime size 1..N, one multiply-accumulate per clock, using a start/busy/done handshake.
- Adds runtime wrap/saturate overflow mode, a sticky overflow flag and size validation.
- Sits between the MPU instruction decoder (start, size) and the matrix register file (flattened operands and result).

Parameters:
- N, 5, maximum matrix dimension; buses hold N*N elements.
- DATA_W, 8, signed element width for A, B and C.
- SIZE_W, $clog2(N+1), width of the size port.
- ACC_W, 2*DATA_W+$clog2(N), accumulator width; never overflows for any legal size.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- size  in  SIZE_W  active dimension; legal range 1..N.
- saturate  in  1  0 = two's-complement wrap, 1 = clamp to DATA_W range.
- matrix_a  in  [0:N*N*DATA_W-1]  flattened signed A.
- matrix_b  in  [0:N*N*DATA_W-1]  flattened signed B.
- result  out  [0:N*N*DATA_W-1]  flattened signed C, registered.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  some element's exact sum exceeded DATA_W range in the last operation.
- error  out  1  last request had an illegal size.

Behaviour:
- Layout: element (r,c) occupies [DATA_W*(r*N+c) +: DATA_W]. Element (0,0) is the most significant field. result uses the same layout, not transposed.
- Reset (reset_n=0 at a rising edge): state IDLE; result, busy, done, overflow and error all 0. An operation in progress is aborted with no partial result kept.
- States: IDLE, MAC, DONE.
- IDLE, start=1 with legal size, at edge E0:
  - Register matrix_a, matrix_b, size and saturate.
  - Clear result, overflow, error and the accumulator; set i=j=k=0.
  - busy goes to 1; go to MAC.
- IDLE, start=1 with size=0 or size>N:
  - Register error=1, clear result and overflow.
  - Go to DONE without asserting busy.
- MAC, each edge:
  - Compute acc + a[i][k]*b[k][j] at full ACC_W precision.
  - k<size-1: store the sum in acc and increment k.
  - k==size-1: reduce the sum, write it to result(i,j), clear acc and k, advance j. When j wraps (j==size-1), advance i.
  - Element order is i-major, then j, then k.
- Reduction:
  - Wrap mode: take the low DATA_W bits.
  - Saturate mode: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - overflow is set (sticky for the operation) whenever the exact sum is outside that range, in either mode.
- Completion: the last element is written at edge E(size^3). busy falls and state goes to DONE at that same edge. done=1 for exactly one cycle. DONE returns to IDLE at the next edge.
- Latency: done is high in the cycle following edge E(size^3). For size=5, that is after 125 MAC edges.
- start is ignored in MAC and in DONE.
- Operand and mode inputs may change freely while busy; they are not re-sampled.
- result, overflow and error hold their values until the next accepted start or reset.
- Elements outside size x size read as 0.
- Reset has priority over every other event, including start in the same cycle.

Decomposition:
- Package mpu_pkg:
  - DATA_W and N defaults.
  - State enum {IDLE, MAC, DONE}.
  - Function elem_offset(r,c,N).
  - Function reduce(sum, saturate) that returns the value and an overflow bit.
- Sub-module mpu_mac_sat (combinational): takes acc, a and b; outputs next_acc, reduced and ovf.
- Top level holds the FSM, the i/j/k counters and the operand/result registers.

Test Plan:
- Identity: A(r,c)=5r+c+1, B=I, size=5, wrap -> result==A. done is high in the cycle after edge 125; overflow=0, error=0.
- Wrap vs saturate, size=5, B all 1:
  - A all 100, wrap -> every element -12 (500 mod 256); overflow=1.
  - A all 100, saturate -> every element 127.
  - A all -100, wrap -> every element 12.
  - A all -100, saturate -> every element -128.
- Sub-size: size=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], all other input elements 9 -> result [[19,22],[43,50]] and remaining 21 elements 0. done follows edge 8.
- Illegal size: size=0, then size=6 -> busy stays 0, done pulses one cycle after the start edge, error=1, result all 0. A following legal start clears error.
- Reset mid-operation: drop reset_n for one cycle at MAC edge 40 -> all outputs 0, state IDLE. A new identity op then completes with correct data.
- Handshake: hold start high through the whole op and change matrix_a while busy -> the result reflects the originally captured A. The next op is accepted exactly at the IDLE edge after the done cycle, and done pulses once per op.
